imem_loader: RTL and testbench

Boot-time instruction loader sitting directly upstream of the instruction memory in the pipelined MIPS core. Accepts a byte stream (header word count plus program words) over a valid/ready handshake, assembles little-endian 32-bit words and drives the instruction memory write port (`wr_instr_imem_top` / `wr_en_imem_top`). Holds the fetch pipeline in reset until the image is fully written, then releases it.

---
 rtl/imem_loader.sv | 145 ++++++++++++++
 tb/tb_imem_loader.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction loader: turns a little-endian byte stream (word count, then program
// words) into instruction-memory writes and holds the core in reset until the image is complete.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             byte_valid_i,
    input  logic [7:0]       byte_data_i,
    output logic             byte_ready_o,
    input  logic             restart_i,
    output logic             wr_en_imem_o,
    output logic [31:0]      wr_addr_imem_o,
    output logic [31:0]      wr_instr_imem_o,
    output logic             core_hold_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] words_loaded_o
);

    // state | meaning
    // HDR   | assembling the 32-bit word count
    // DATA  | assembling program words, one write per completed word
    // DONE  | image written; core released once done_o is up
    // ERR   | word count rejected; waiting for restart
    typedef enum logic [1:0] {
        ST_HDR,
        ST_DATA,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       byte_cnt_q;
    logic [23:0]      asm_q;
    logic [CNT_W-1:0] n_words_q;
    logic [CNT_W-1:0] words_q;
    logic             wr_en_q;
    logic [31:0]      wr_addr_q;
    logic [31:0]      wr_instr_q;
    logic             done_q;

    logic        accept;
    logic        word_done;
    logic        hdr_word_done;
    logic        data_word_done;
    logic        hdr_ok;
    logic        restart_ok;
    logic [31:0] full_word;

    assign full_word      = {byte_data_i, asm_q};
    assign accept         = byte_valid_i & byte_ready_o;
    assign word_done      = accept && (byte_cnt_q == 2'd3);
    assign hdr_word_done  = word_done && (state_q == ST_HDR);
    assign data_word_done = word_done && (state_q == ST_DATA);
    assign hdr_ok         = (full_word != 32'd0) && (full_word <= 32'(MAX_WORDS));
    // DONE only counts as settled once done_o is up, so a restart during the final write is dropped.
    assign restart_ok     = restart_i && (((state_q == ST_DONE) && done_q) || (state_q == ST_ERR));

    always_comb begin
        state_d      = state_q;
        byte_ready_o = 1'b0;
        case (state_q)
            ST_HDR: begin
                byte_ready_o = 1'b1;
                if (hdr_word_done) begin
                    state_d = hdr_ok ? ST_DATA : ST_ERR;
                end
            end
            ST_DATA: begin
                byte_ready_o = 1'b1;
                if (data_word_done && (words_q == n_words_q - CNT_W'(1))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (restart_ok) begin
                    state_d = ST_HDR;
                end
            end
            ST_ERR: begin
                if (restart_ok) begin
                    state_d = ST_HDR;
                end
            end
            default: state_d = ST_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_HDR;
            byte_cnt_q <= 2'd0;
            asm_q      <= 24'd0;
            n_words_q  <= '0;
            words_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= BASE_ADDR;
            wr_instr_q <= 32'd0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_en_q <= data_word_done;
            if (restart_ok) begin
                byte_cnt_q <= 2'd0;
                asm_q      <= 24'd0;
                n_words_q  <= '0;
                words_q    <= '0;
                done_q     <= 1'b0;
            end else begin
                if (accept) begin
                    byte_cnt_q <= byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0:    asm_q[7:0]   <= byte_data_i;
                        2'd1:    asm_q[15:8]  <= byte_data_i;
                        2'd2:    asm_q[23:16] <= byte_data_i;
                        default: ;
                    endcase
                end
                if (hdr_word_done && hdr_ok) begin
                    n_words_q <= full_word[CNT_W-1:0];
                end
                if (data_word_done) begin
                    wr_addr_q  <= BASE_ADDR + (32'(words_q) << 2);
                    wr_instr_q <= full_word;
                    words_q    <= words_q + CNT_W'(1);
                end
                if (state_q == ST_DONE) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign wr_en_imem_o    = wr_en_q;
    assign wr_addr_imem_o  = wr_addr_q;
    assign wr_instr_imem_o = wr_instr_q;
    assign done_o          = done_q;
    assign err_o           = (state_q == ST_ERR);
    assign core_hold_o     = ~done_q;
    assign words_loaded_o  = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized images compared against a
// write-list model built from the header/word rules.
module tb_imem_loader;

    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam int          MAXW  = 1024;
    localparam int          CNT_W = 16;

    logic             clk;
    logic             reset;
    logic             byte_valid_i;
    logic [7:0]       byte_data_i;
    logic             byte_ready_o;
    logic             restart_i;
    logic             wr_en_imem_o;
    logic [31:0]      wr_addr_imem_o;
    logic [31:0]      wr_instr_imem_o;
    logic             core_hold_o;
    logic             done_o;
    logic             err_o;
    logic [CNT_W-1:0] words_loaded_o;

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .byte_valid_i    (byte_valid_i),
        .byte_data_i     (byte_data_i),
        .byte_ready_o    (byte_ready_o),
        .restart_i       (restart_i),
        .wr_en_imem_o    (wr_en_imem_o),
        .wr_addr_imem_o  (wr_addr_imem_o),
        .wr_instr_imem_o (wr_instr_imem_o),
        .core_hold_o     (core_hold_o),
        .done_o          (done_o),
        .err_o           (err_o),
        .words_loaded_o  (words_loaded_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Write log captured away from the active edge.
    int          cyc = 0;
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    int          got_cyc[$];
    int          done_cyc = -1;
    int          last_acc = -1;
    bit          dbl = 0;
    logic        prev_wr = 1'b0;
    logic        prev_done = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (wr_en_imem_o === 1'b1) begin
            got_addr.push_back(wr_addr_imem_o);
            got_data.push_back(wr_instr_imem_o);
            got_cyc.push_back(cyc);
            if (prev_wr) dbl = 1;
        end
        if (done_o === 1'b1 && !prev_done) done_cyc = cyc;
        prev_wr   = wr_en_imem_o;
        prev_done = done_o;
    end

    // Reference: the image and the writes it must produce.
    logic [31:0] img[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    function automatic void model_build(input logic [31:0] n);
        exp_addr.delete();
        exp_data.delete();
        if (n != 0 && n <= MAXW) begin
            for (int i = 0; i < int'(n); i++) begin
                exp_addr.push_back(BASE + 32'(4 * i));
                exp_data.push_back(img[i]);
            end
        end
    endfunction

    task automatic clear_log();
        got_addr.delete();
        got_data.delete();
        got_cyc.delete();
        done_cyc = -1;
        dbl = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        @(negedge clk);
        repeat (gap) @(negedge clk);
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        t = 0;
        while (!byte_ready_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!byte_ready_o) begin
            checks++;
            failures++;
            $display("FAIL send_byte_timeout ready=%0b required=1", byte_ready_o);
            byte_valid_i = 1'b0;
        end else begin
            @(posedge clk);
            last_acc = cyc;
            #1 byte_valid_i = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        logic [31:0] v;
        v = w;
        for (int j = 0; j < 4; j++) begin
            send_byte(v[7:0], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
            v = v >> 8;
        end
    endtask

    task automatic load_image(input logic [31:0] n, input int max_gap);
        send_word(n, max_gap);
        for (int i = 0; i < img.size(); i++) send_word(img[i], max_gap);
    endtask

    task automatic wait_settle();
        int t;
        t = 0;
        while (!(done_o || err_o) && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        restart_i = 1'b1;
        @(posedge clk);
        #1 restart_i = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        byte_valid_i = 1'b0;
        byte_data_i = 8'h00;
        restart_i = 1'b0;
        #2 reset = 1'b0;
        #3;
        checks++;
        if ({byte_ready_o, core_hold_o, wr_en_imem_o, done_o, err_o} !== 5'b11000) begin
            failures++;
            $display("FAIL reset_flags got=%b required=11000",
                     {byte_ready_o, core_hold_o, wr_en_imem_o, done_o, err_o});
        end
        checks++;
        if (wr_addr_imem_o !== BASE) begin
            failures++;
            $display("FAIL reset_addr got=%h required=%h", wr_addr_imem_o, BASE);
        end
        checks++;
        if (wr_instr_imem_o !== 32'd0 || words_loaded_o !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h/%0d required=0/0", wr_instr_imem_o, words_loaded_o);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        clear_log();
        img = '{32'h1234_5678, 32'hDEAD_BEEF};
        load_image(32'd2, 0);
        wait_settle();
        checks++;
        if (got_addr.size() != 2) begin
            failures++;
            $display("FAIL basic_count got=%0d required=2", got_addr.size());
        end else begin
            checks++;
            if (got_addr[0] !== BASE || got_data[0] !== 32'h1234_5678) begin
                failures++;
                $display("FAIL basic_w0 got=%h:%h required=%h:12345678", got_addr[0], got_data[0], BASE);
            end
            checks++;
            if (got_addr[1] !== BASE + 32'd4 || got_data[1] !== 32'hDEAD_BEEF) begin
                failures++;
                $display("FAIL basic_w1 got=%h:%h required=%h:deadbeef", got_addr[1], got_data[1], BASE + 32'd4);
            end
            checks++;
            if (got_cyc[1] != last_acc + 1) begin
                failures++;
                $display("FAIL basic_wr_latency got=%0d required=%0d", got_cyc[1], last_acc + 1);
            end
            checks++;
            if (done_cyc != got_cyc[1] + 1) begin
                failures++;
                $display("FAIL basic_done_timing got=%0d required=%0d", done_cyc, got_cyc[1] + 1);
            end
        end
        checks++;
        if (words_loaded_o !== 16'd2 || done_o !== 1'b1 || core_hold_o !== 1'b0 || byte_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL basic_final got=wl%0d done%0b hold%0b rdy%0b required=wl2 done1 hold0 rdy0",
                     words_loaded_o, done_o, core_hold_o, byte_ready_o);
        end
        checks++;
        if (dbl) begin
            failures++;
            $display("FAIL basic_strobe_width got=multi-cycle required=single");
        end
    endtask

    task automatic test_bad_header();
        logic [31:0] bad[4];
        bad = '{32'd0, 32'(MAXW + 1), 32'h0001_0001, 32'hFFFF_FFFF};
        for (int k = 0; k < 4; k++) begin
            pulse_restart();
            clear_log();
            send_word(bad[k], 0);
            checks++;
            if (byte_ready_o !== 1'b0 || err_o !== 1'b1) begin
                failures++;
                $display("FAIL err_entry hdr=%h got=rdy%0b err%0b required=rdy0 err1", bad[k], byte_ready_o, err_o);
            end
            repeat (3) @(negedge clk);
            checks++;
            if (err_o !== 1'b1 || core_hold_o !== 1'b1 || done_o !== 1'b0 || got_addr.size() != 0) begin
                failures++;
                $display("FAIL err_state hdr=%h got=err%0b hold%0b done%0b writes%0d required=1 1 0 0",
                         bad[k], err_o, core_hold_o, done_o, got_addr.size());
            end
            pulse_restart();
            checks++;
            if (err_o !== 1'b0 || byte_ready_o !== 1'b1 || core_hold_o !== 1'b1) begin
                failures++;
                $display("FAIL err_restart got=err%0b rdy%0b hold%0b required=0 1 1", err_o, byte_ready_o, core_hold_o);
            end
            img = '{$urandom()};
            load_image(32'd1, 0);
            wait_settle();
            checks++;
            if (got_addr.size() != 1 || got_addr[0] !== BASE || got_data[0] !== img[0] || done_o !== 1'b1) begin
                failures++;
                $display("FAIL err_reload writes=%0d done=%0b required writes=1 %h:%h done=1",
                         got_addr.size(), done_o, BASE, img[0]);
            end
        end
    endtask

    task automatic test_gaps();
        for (int r = 0; r < 3; r++) begin
            pulse_restart();
            clear_log();
            img = '{$urandom()};
            load_image(32'd1, 5);
            wait_settle();
            checks++;
            if (got_addr.size() != 1 || got_addr[0] !== BASE || got_data[0] !== img[0]) begin
                failures++;
                $display("FAIL gaps_write writes=%0d got=%h:%h required=%h:%h", got_addr.size(),
                         (got_addr.size() > 0) ? got_addr[0] : 32'hx, (got_data.size() > 0) ? got_data[0] : 32'hx,
                         BASE, img[0]);
            end
            checks++;
            if (words_loaded_o !== 16'd1 || done_o !== 1'b1) begin
                failures++;
                $display("FAIL gaps_done got=wl%0d done%0b required=wl1 done1", words_loaded_o, done_o);
            end
        end
    endtask

    task automatic test_reset_midload();
        logic [31:0] w1;
        pulse_restart();
        clear_log();
        img = '{$urandom(), $urandom(), $urandom()};
        w1 = img[1];
        send_word(32'd3, 0);
        send_word(img[0], 0);
        send_byte(w1[7:0], 0);
        send_byte(w1[15:8], 0);
        reset = 1'b0;
        #1;
        checks++;
        if ({byte_ready_o, core_hold_o, wr_en_imem_o, done_o, err_o} !== 5'b11000 || words_loaded_o !== '0) begin
            failures++;
            $display("FAIL midreset_outputs got=%b wl%0d required=11000 wl0",
                     {byte_ready_o, core_hold_o, wr_en_imem_o, done_o, err_o}, words_loaded_o);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (got_addr.size() != 1) begin
            failures++;
            $display("FAIL midreset_strobes got=%0d required=1", got_addr.size());
        end
        reset = 1'b1;
        clear_log();
        img = '{$urandom()};
        load_image(32'd1, 0);
        wait_settle();
        checks++;
        if (got_addr.size() != 1 || got_addr[0] !== BASE || got_data[0] !== img[0] || done_o !== 1'b1) begin
            failures++;
            $display("FAIL midreset_reload writes=%0d done=%0b required writes=1 %h:%h done=1",
                     got_addr.size(), done_o, BASE, img[0]);
        end
    endtask

    task automatic test_max();
        int bad;
        pulse_restart();
        clear_log();
        img.delete();
        for (int i = 0; i < MAXW; i++) img.push_back(32'(i));
        model_build(32'(MAXW));
        load_image(32'(MAXW), 0);
        wait_settle();
        checks++;
        if (got_addr.size() != exp_addr.size()) begin
            failures++;
            $display("FAIL max_count got=%0d required=%0d", got_addr.size(), exp_addr.size());
        end else begin
            bad = 0;
            for (int i = 0; i < exp_addr.size(); i++) begin
                checks++;
                if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                    failures++;
                    if (bad < 5) $display("FAIL max_write[%0d] got=%h:%h required=%h:%h",
                                          i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
                    bad++;
                end
            end
        end
        checks++;
        if (words_loaded_o !== 16'(MAXW) || done_o !== 1'b1 || core_hold_o !== 1'b0) begin
            failures++;
            $display("FAIL max_final got=wl%0d done%0b hold%0b required=wl%0d done1 hold0",
                     words_loaded_o, done_o, core_hold_o, MAXW);
        end
    endtask

    task automatic test_restart_done();
        pulse_restart();
        checks++;
        if (core_hold_o !== 1'b1 || words_loaded_o !== '0 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL restart_clear got=hold%0b wl%0d done%0b required=hold1 wl0 done0",
                     core_hold_o, words_loaded_o, done_o);
        end
        clear_log();
        img = '{32'hCAFE_F00D};
        load_image(32'd1, 0);
        wait_settle();
        checks++;
        if (got_addr.size() != 1 || got_addr[0] !== BASE || got_data[0] !== 32'hCAFE_F00D || done_o !== 1'b1) begin
            failures++;
            $display("FAIL restart_reload writes=%0d done=%0b required writes=1 %h:cafef00d done=1",
                     got_addr.size(), done_o, BASE);
        end
    endtask

    // Random images; restart_i is held high while loading and must be ignored.
    task automatic test_random();
        logic [31:0] n;
        for (int r = 0; r < 6; r++) begin
            pulse_restart();
            clear_log();
            n = 32'($urandom_range(1, 6));
            img.delete();
            for (int i = 0; i < int'(n); i++) img.push_back($urandom());
            model_build(n);
            restart_i = (r % 2) == 1;
            load_image(n, 2);
            restart_i = 1'b0;
            wait_settle();
            checks++;
            if (got_addr.size() != exp_addr.size()) begin
                failures++;
                $display("FAIL rand_count n=%0d got=%0d required=%0d", n, got_addr.size(), exp_addr.size());
            end else begin
                for (int i = 0; i < exp_addr.size(); i++) begin
                    checks++;
                    if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                        failures++;
                        $display("FAIL rand_write[%0d] got=%h:%h required=%h:%h",
                                 i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
                    end
                end
            end
            checks++;
            if (words_loaded_o !== 16'(n) || done_o !== 1'b1 || dbl) begin
                failures++;
                $display("FAIL rand_final got=wl%0d done%0b dbl%0b required=wl%0d done1 dbl0",
                         words_loaded_o, done_o, dbl, n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_header();
        test_gaps();
        test_reset_midload();
        test_max();
        test_restart_done();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
